// File: rtl/router_pkg.sv
// router_pkg: shared types, constants and helpers for the router fabric.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FWD   = 2'd2
    } state_t;

    localparam int PKT_CNT_W = 16;

    // Round-robin pointer advance: the channel after cur, wrapping at n.
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/router_if.sv
// router_if: input channels and the single output port of the router fabric.
// The fabric takes the slave view; a traffic source/sink takes the master view.
interface router_if #(
    parameter int NPORTS = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    localparam int SRC_W = $clog2(NPORTS);

    logic [NPORTS*DATA_W-1:0] in_data;
    logic [NPORTS-1:0]        in_valid;
    logic [NPORTS-1:0]        in_last;
    logic [NPORTS-1:0]        in_ready;

    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;
    logic [ADDR_W-1:0]        out_addr;
    logic [SRC_W-1:0]         out_src;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_addr, out_src
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_addr, out_src
    );

endinterface

// File: rtl/router_port_fifo.sv
// router_port_fifo: per-channel buffer holding {last, data} beats.
// Head entry is visible on rdata without a read latency so the fabric can
// forward one beat per cycle. DEPTH must be a power of two.
module router_port_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; occupancy unchanged on push+pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/router_fabric.sv
// router_fabric: NPORTS buffered input channels, round-robin packet arbiter,
// single valid/ready output. Grant is held from header to last beat.
// Optional feature macro: ROUTER_STATS_EN enables the completed-packet
// counter on pkt_count; without it pkt_count reads zero.
//
//   state | meaning
//   IDLE  | no packet in flight, waiting for any non-empty FIFO
//   GRANT | pick channel, latch out_src and header destination
//   FWD   | stream beats from the granted FIFO until last is popped
module router_fabric
    import router_pkg::*;
#(
    parameter int NPORTS     = 4,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    router_if.slave              bus,
    output logic                 busy,
    output logic [PKT_CNT_W-1:0] pkt_count
);
    localparam int SRC_W = $clog2(NPORTS);

    state_t              state;
    logic [SRC_W-1:0]    rr_ptr;
    logic [SRC_W-1:0]    out_src_r;
    logic [ADDR_W-1:0]   out_addr_r;
    logic [SRC_W-1:0]    sel_idx;

    logic [NPORTS-1:0]   fifo_push;
    logic [NPORTS-1:0]   fifo_pop;
    logic [NPORTS-1:0]   fifo_full;
    logic [NPORTS-1:0]   fifo_empty;
    logic [DATA_W:0]     fifo_rdata [NPORTS];

    logic [DATA_W:0]     head;
    logic                out_valid_w;
    logic                fire;

    assign head        = fifo_rdata[out_src_r];
    assign out_valid_w = (state == FWD) && !fifo_empty[out_src_r];
    assign fire        = out_valid_w && bus.out_ready;

    for (genvar g = 0; g < NPORTS; g++) begin : g_port
        assign fifo_push[g] = bus.in_valid[g] && !fifo_full[g];
        assign fifo_pop[g]  = fire && (out_src_r == SRC_W'(g));

        router_port_fifo #(
            .WIDTH (DATA_W + 1),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[g]),
            .wdata ({bus.in_last[g], bus.in_data[g*DATA_W +: DATA_W]}),
            .pop   (fifo_pop[g]),
            .rdata (fifo_rdata[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    // First non-empty channel at or after rr_ptr; scanning backwards lets the
    // nearest candidate win without a priority chain of found flags.
    always_comb begin
        sel_idx = rr_ptr;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (!fifo_empty[(int'(rr_ptr) + k) % NPORTS]) begin
                sel_idx = SRC_W'((int'(rr_ptr) + k) % NPORTS);
            end
        end
    end

    // Packet FSM: grant, header capture, and pointer advance after last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            out_src_r  <= '0;
            out_addr_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|(~fifo_empty)) state <= GRANT;
                end
                GRANT: begin
                    out_src_r  <= sel_idx;
                    out_addr_r <= fifo_rdata[sel_idx][ADDR_W-1:0];
                    state      <= FWD;
                end
                FWD: begin
                    if (fire && head[DATA_W]) begin
                        rr_ptr <= SRC_W'(rr_next(int'(out_src_r), NPORTS));
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = ~fifo_full;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_valid_w ? head[DATA_W-1:0] : '0;
    assign bus.out_last  = out_valid_w && head[DATA_W];
    assign bus.out_addr  = out_addr_r;
    assign bus.out_src   = out_src_r;
    assign busy          = (state != IDLE);

`ifdef ROUTER_STATS_EN
    logic [PKT_CNT_W-1:0] pkt_cnt_r;

    // Count every packet whose last beat leaves the fabric; wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_r <= '0;
        end else if (fire && head[DATA_W]) begin
            pkt_cnt_r <= pkt_cnt_r + PKT_CNT_W'(1);
        end
    end

    assign pkt_count = pkt_cnt_r;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_router_fabric.sv
// tb_router_fabric: scoreboard bench. The driver records every accepted beat
// in a per-channel expected queue; the monitor checks each forwarded beat
// against the queue of the channel it came from, plus grant order, header
// address and hold-under-backpressure.
module tb_router_fabric;
    localparam int NP = 4;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FD = 4;

    typedef logic [DW:0] beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] pkt_count;

    int total = 0;
    int bad   = 0;

    beat_t drv_q [NP][$];
    beat_t exp_q [NP][$];
    int    exp_src_q [$];
    int    stim_pkts = 0;

    bit force_low  = 1'b0;
    bit rand_ready = 1'b0;
    bit rand_gap   = 1'b0;

    router_if #(.NPORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();

    router_fabric #(
        .NPORTS     (NP),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (drv_q[i].size() != 0 || exp_q[i].size() != 0) p = 1'b1;
        end
        return p;
    endfunction

    task automatic queue_pkt(input int ch, input logic [7:0] first, input int len);
        for (int b = 0; b < len; b++) begin
            drv_q[ch].push_back(beat_t'({(b == len - 1), 8'(first + b)}));
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pending() || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", {31'b0, pending()}, 32'd0);
    endtask

    task automatic wait_valid(input int src, input int budget);
        int n = 0;
        while (!(bus.out_valid && int'(bus.out_src) == src) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", {31'b0, bus.out_valid}, 32'd1);
    endtask

    // Driver: acceptance sampled at negedge, new beats presented after posedge.
    logic [NP-1:0]    drv_acc;
    logic [NP-1:0]    drv_v;
    logic [NP-1:0]    drv_l;
    logic [NP*DW-1:0] drv_d;
    beat_t            drv_b;

    initial begin
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            drv_acc = bus.in_valid & bus.in_ready & {NP{!rst}};
            @(posedge clk);
            #1;
            drv_v = '0;
            drv_l = '0;
            drv_d = '0;
            for (int i = 0; i < NP; i++) begin
                if (drv_acc[i] && drv_q[i].size() != 0) begin
                    drv_b = drv_q[i].pop_front();
                    exp_q[i].push_back(drv_b);
                    if (drv_b[DW]) stim_pkts++;
                end
                if (drv_q[i].size() != 0 && !(rand_gap && $urandom_range(0, 3) == 0)) begin
                    drv_v[i]            = 1'b1;
                    drv_l[i]            = drv_q[i][0][DW];
                    drv_d[i*DW +: DW]   = drv_q[i][0][DW-1:0];
                end
            end
            bus.in_valid  = drv_v;
            bus.in_last   = drv_l;
            bus.in_data   = drv_d;
            bus.out_ready = force_low ? 1'b0 :
                            (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: checks every accepted output beat and output stability under stall.
    bit              mon_in_pkt = 1'b0;
    bit              mon_stall  = 1'b0;
    int              mon_src;
    logic [AW-1:0]   mon_addr;
    beat_t           mon_e;
    logic [DW-1:0]   st_data;
    logic            st_last;
    logic [AW-1:0]   st_addr;
    logic [1:0]      st_src;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_in_pkt = 1'b0;
                mon_stall  = 1'b0;
            end else begin
                if (mon_stall) begin
                    chk("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                    chk("hold_data", bus.out_data, st_data);
                    chk("hold_last", {31'b0, bus.out_last}, {31'b0, st_last});
                    chk("hold_addr", bus.out_addr, st_addr);
                    chk("hold_src", bus.out_src, st_src);
                end
                if (bus.out_valid) begin
                    if (bus.out_ready) begin
                        if (!mon_in_pkt) begin
                            mon_src = int'(bus.out_src);
                            if (exp_src_q.size() != 0) begin
                                chk("grant_src", bus.out_src, exp_src_q.pop_front());
                            end
                        end else begin
                            chk("src_held", bus.out_src, mon_src);
                        end
                        chk("beat_expected", {31'b0, (exp_q[mon_src].size() != 0)}, 32'd1);
                        if (exp_q[mon_src].size() != 0) begin
                            mon_e = exp_q[mon_src].pop_front();
                            if (!mon_in_pkt) mon_addr = mon_e[AW-1:0];
                            chk("out_data", bus.out_data, mon_e[DW-1:0]);
                            chk("out_last", {31'b0, bus.out_last}, {31'b0, mon_e[DW]});
                            chk("out_addr", bus.out_addr, mon_addr);
                        end
                        mon_in_pkt = !bus.out_last;
                        mon_stall  = 1'b0;
                    end else begin
                        mon_stall = 1'b1;
                        st_data   = bus.out_data;
                        st_last   = bus.out_last;
                        st_addr   = bus.out_addr;
                        st_src    = bus.out_src;
                    end
                end else begin
                    mon_stall = 1'b0;
                end
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_last", {31'b0, bus.out_last}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_addr", bus.out_addr, 32'd0);
        chk("rst_out_src", bus.out_src, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_pkt_count", pkt_count, 32'd0);
        chk("rst_in_ready", bus.in_ready, 32'hF);
        rst = 1'b0;

        // Single-beat fairness: all four channels at once, served 0,1,2,3
        @(negedge clk);
        queue_pkt(0, 8'h10, 1);
        queue_pkt(1, 8'h21, 1);
        queue_pkt(2, 8'h32, 1);
        queue_pkt(3, 8'h43, 1);
        for (int i = 0; i < NP; i++) exp_src_q.push_back(i);
        drain(200);
        chk("fair_src_all_seen", exp_src_q.size(), 32'd0);

        // Latency from push into empty FIFO to out_valid
        @(negedge clk);
        queue_pkt(1, 8'h5B, 1);
        exp_src_q.push_back(1);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("lat_t0_valid", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #2;
        chk("lat_t1_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("lat_t1_busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #2;
        chk("lat_t2_valid", {31'b0, bus.out_valid}, 32'd1);
        drain(100);

        // Backpressure: data must stay on the header beat during the stall
        force_low = 1'b1;
        @(negedge clk);
        queue_pkt(1, 8'hA0, 4);
        exp_src_q.push_back(1);
        wait_valid(1, 50);
        for (int c = 0; c < 5; c++) begin
            chk("bp_stall_data", bus.out_data, 32'hA0);
            @(negedge clk);
        end
        force_low = 1'b0;
        drain(100);

        // FIFO full on channel 3 while channel 0 holds the grant
        force_low = 1'b1;
        @(negedge clk);
        queue_pkt(0, 8'hB0, 2);
        exp_src_q.push_back(0);
        exp_src_q.push_back(3);
        wait_valid(0, 50);
        queue_pkt(3, 8'hC0, 6);
        repeat (10) @(negedge clk);
        chk("full_in_ready3", {31'b0, bus.in_ready[3]}, 32'd0);
        chk("full_accepted", exp_q[3].size(), FD);
        chk("full_waiting", drv_q[3].size(), 32'd2);
        chk("full_stall_data", bus.out_data, 32'hB0);
        force_low = 1'b0;
        drain(200);

        // Round-robin resume after channel 2 with 0 and 3 pending
        force_low = 1'b1;
        @(negedge clk);
        queue_pkt(2, 8'h20, 2);
        exp_src_q.push_back(2);
        exp_src_q.push_back(3);
        exp_src_q.push_back(0);
        wait_valid(2, 50);
        queue_pkt(0, 8'h61, 1);
        queue_pkt(3, 8'h72, 1);
        repeat (4) @(negedge clk);
        force_low = 1'b0;
        drain(200);
        chk("rr_src_all_seen", exp_src_q.size(), 32'd0);

        // Reset during a 3-beat packet
        force_low = 1'b1;
        @(negedge clk);
        queue_pkt(1, 8'hD4, 3);
        wait_valid(1, 50);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_in_ready", bus.in_ready, 32'hF);
        chk("mid_rst_pkt_count", pkt_count, 32'd0);
        for (int i = 0; i < NP; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
        end
        exp_src_q.delete();
        stim_pkts = 0;
        force_low = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        queue_pkt(2, 8'hE2, 3);
        exp_src_q.push_back(2);
        drain(200);
        chk("post_rst_src_seen", exp_src_q.size(), 32'd0);

        // Statistics: five more packets
        @(negedge clk);
        for (int c = 0; c < 5; c++) queue_pkt(c % NP, 8'(8'h80 + c * 16), 2);
        drain(300);
`ifdef ROUTER_STATS_EN
        chk("stats_count", pkt_count, 32'd6);
`else
        chk("stats_count", pkt_count, 32'd0);
`endif

        // Randomized traffic with random gaps and random backpressure
        rand_ready = 1'b1;
        rand_gap   = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int ch;
            int len;
            ch  = $urandom_range(0, NP - 1);
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                drv_q[ch].push_back(beat_t'({(b == len - 1), 8'($urandom)}));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(3000);
        rand_ready = 1'b0;
        rand_gap   = 1'b0;
        repeat (3) @(negedge clk);
`ifdef ROUTER_STATS_EN
        chk("final_pkt_count", pkt_count, 16'(stim_pkts));
`else
        chk("final_pkt_count", pkt_count, 32'd0);
`endif
        chk("final_busy", {31'b0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_fabric.md
# router_fabric

Parametrised successor to the four-port data path: NPORTS input channels each feed a small FIFO, a round-robin arbiter selects one channel at a time, and whole packets are forwarded to a single output port with valid/ready flow control. It replaces the fixed one-hot bus select and X-driven idle bus. It adds buffering, fair arbitration, packet framing and source tagging.

## Interface
- NPORTS, 4, number of input channels (2..8)
- DATA_W, 8, beat width in bits
- ADDR_W, 4, destination field width; taken from the low bits of the header beat
- FIFO_DEPTH, 4, entries per input FIFO; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  NPORTS*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- in_valid  in  NPORTS  beat present on channel i
- in_last  in  NPORTS  beat is the final beat of its packet
- in_ready  out  NPORTS  channel i FIFO can accept a beat
- out_data  out  DATA_W  forwarded beat
- out_valid  out  1  out_data is valid
- out_last  out  1  final beat of the current packet
- out_ready  in  1  downstream accepts the beat
- out_addr  out  ADDR_W  destination of the current packet, held for the whole packet
- out_src  out  $clog2(NPORTS)  index of the granted channel
- busy  out  1  a packet is in flight (state ≠ IDLE)
- pkt_count  out  16  completed-packet counter (see Configuration)

## Operation
- Per-channel FIFO stores {last, data}. Push when in_valid && in_ready. in_ready = !full; it does not look ahead to a same-cycle pop.
- FSM states:
  - IDLE → GRANT when any FIFO is non-empty.
  - GRANT (1 cycle):
    - Arbiter picks the first non-empty channel at or after rr_ptr, wrapping modulo NPORTS.
    - Latches the selection into out_src.
    - Latches the FIFO head's low ADDR_W bits into out_addr.
    - → FWD.
  - FWD:
    - out_data/out_last/out_valid come from the head of the granted FIFO. out_valid = !empty.
    - Pop on out_valid && out_ready.
    - On a pop with last=1: → IDLE, and rr_ptr ← out_src+1 (wraps to 0).
- The header beat is forwarded as the first beat of the packet. It is not consumed by the fabric.
- Packet length is unbounded. A single-beat packet (header with last=1) is legal.
- The grant is held until last. Other channels keep buffering, and stall via in_ready when their FIFOs are full.
- Granted FIFO underruns mid-packet: out_valid drops and the FSM stays in FWD. No other channel may be granted.
- Output registers hold while out_valid && !out_ready: out_data, out_last, out_addr and out_src are all stable.

## Timing
- Reset values:
  - all FIFOs empty; in_ready all 1
  - out_valid 0, out_last 0, out_data 0, out_addr 0, out_src 0
  - busy 0, pkt_count 0, rr_ptr 0, state IDLE
- Reset asserted mid-packet: all of the above takes effect at the next edge. Buffered beats are discarded. There is no partial-packet recovery.
- Latency: a beat pushed into an empty FIFO at edge t, with the fabric IDLE, gives out_valid=1 after edge t+2 (IDLE→GRANT at t+1, FWD at t+2).
- Throughput: one beat per cycle inside a packet. There is 2 cycles of dead time between packets (IDLE, GRANT).
- Simultaneous push and pop on the same FIFO: both happen, and the count is unchanged.
- Push while full is ignored, because in_ready=0.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.

## Configuration
- ROUTER_STATS_EN defined:
  - pkt_count increments by 1 on each pop with last=1.
  - It wraps from 0xFFFF to 0.
  - rst clears it.
- ROUTER_STATS_EN undefined:
  - The counter logic is not compiled.
  - pkt_count is tied to 16'h0000.
  - The port list is unchanged.

## Structure
- Package router_pkg holds:
  - state enum {IDLE, GRANT, FWD}
  - localparam PKT_CNT_W = 16
  - function to compute the rr_ptr increment with wrap
- Sub-module router_port_fifo, parametrised by DATA_W+1 and FIFO_DEPTH, instantiated NPORTS times via generate.
- The arbiter and FSM stay in the top module.

## Test plan
- Reset mid-packet:
  - Stimulus: assert rst during FWD of a 3-beat packet.
  - Response: next cycle out_valid=0, busy=0 and in_ready=4'b1111. The following packet from channel 2 arrives intact.
- Single-beat fairness:
  - Stimulus: channels 0..3 each push a 1-beat packet in the same cycle, with headers 0x10, 0x21, 0x32, 0x43.
  - Response: out_src sequence 0, 1, 2, 3. out_addr sequence 0, 1, 2, 3.
- Backpressure:
  - Stimulus: a 4-beat packet on channel 1 (0xA0..0xA3), with out_ready held low for 5 cycles after the first out_valid.
  - Response: out_data stays 0xA0 throughout the stall. All four beats then come out in order, with out_last on 0xA3.
- FIFO full:
  - Stimulus: FIFO_DEPTH=4, 6 beats pushed on channel 3 while channel 0 holds the grant and out_ready=0.
  - Response: in_ready[3]=0 after the 4th beat. No beats are lost once the grant reaches channel 3.
- Round-robin resume:
  - Stimulus: channel 2 finishes a packet while channels 0 and 3 are pending.
  - Response: the next grant is 3, then 0.
- Statistics (ROUTER_STATS_EN defined):
  - Stimulus: 5 packets forwarded.
  - Response: pkt_count=5. With the macro undefined, pkt_count=0.
